// File: rtl/div8_loop.sv
// div8_loop: iterative restoring shift-subtract unsigned divider, one quotient bit per clock, MSB first.
// start is accepted in any state and restarts the sequence; done pulses once per completed division.
module div8_loop #(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient_o,
    output logic [W-1:0] remainder_o,
    output logic         div0_o
);
    typedef enum logic {IDLE, CALC} state_t;

    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state, state_nx;
    logic [W-1:0]  q_sh, q_nx;
    logic [W-1:0]  d_r, d_nx;
    logic [W-1:0]  rem, rem_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          busy_nx, done_nx, div0_nx;
    logic [W-1:0]  quo_nx, remo_nx;
    logic [W:0]    t;
    logic          ge;
    logic [W-1:0]  diff;

    // A successful subtract leaves a value below d_r, so W-bit wrap-around arithmetic is exact.
    assign t    = {rem, q_sh[W-1]};
    assign ge   = t >= {1'b0, d_r};
    assign diff = t[W-1:0] - d_r;

    always_comb begin
        state_nx = state;
        q_nx     = q_sh;
        d_nx     = d_r;
        rem_nx   = rem;
        cnt_nx   = cnt;
        busy_nx  = busy;
        done_nx  = 1'b0;
        quo_nx   = quotient_o;
        remo_nx  = remainder_o;
        div0_nx  = div0_o;
        if (start) begin
            q_nx     = dividend_i;
            d_nx     = divisor_i;
            rem_nx   = '0;
            cnt_nx   = '0;
            state_nx = CALC;
            busy_nx  = 1'b1;
        end else if (state == CALC) begin
            q_nx   = {q_sh[W-2:0], ge};
            rem_nx = ge ? diff : t[W-1:0];
            cnt_nx = cnt + 1'b1;
            if (cnt == LAST) begin
                quo_nx   = q_nx;
                remo_nx  = rem_nx;
                div0_nx  = d_r == '0;
                done_nx  = 1'b1;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            q_sh        <= '0;
            d_r         <= '0;
            rem         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
            div0_o      <= 1'b0;
        end else begin
            state       <= state_nx;
            q_sh        <= q_nx;
            d_r         <= d_nx;
            rem         <= rem_nx;
            cnt         <= cnt_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            quotient_o  <= quo_nx;
            remainder_o <= remo_nx;
            div0_o      <= div0_nx;
        end
    end
endmodule

// File: tb/tb_div8_loop.sv
// tb_div8_loop: self-checking bench for div8_loop with directed cases and a randomized back-to-back run.
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_div8_loop;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend_i = '0;
    logic [7:0] divisor_i = '0;
    logic       busy, done, div0_o;
    logic [7:0] quotient_o, remainder_o;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    div8_loop dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend_i(dividend_i), .divisor_i(divisor_i),
        .busy(busy), .done(done), .quotient_o(quotient_o), .remainder_o(remainder_o), .div0_o(div0_o)
    );

    function automatic logic [7:0] ref_q(input logic [7:0] a, input logic [7:0] b);
        return (b == 0) ? 8'hff : 8'(a / b);
    endfunction

    function automatic logic [7:0] ref_r(input logic [7:0] a, input logic [7:0] b);
        return (b == 0) ? a : 8'(a % b);
    endfunction

    // Ends at the falling edge right after the start edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start = 1'b1;
        dividend_i = a;
        divisor_i = b;
        @(negedge clk);
        start = 1'b0;
        dividend_i = $urandom_range(0, 255);
        divisor_i = $urandom_range(0, 255);
    endtask

    // Cycles from the start edge until done is seen; 40 means it never came.
    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({busy, done, div0_o, quotient_o, remainder_o} !== 19'd0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b div0=%b q=%0d r=%0d, required all 0", busy, done, div0_o, quotient_o, remainder_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int k = 0;
        start_op(8'd200, 8'd7);
        while (k < 8) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL basic_busy k=%0d: busy=%b done=%b, required busy=1 done=0", k, busy, done);
            end
            @(negedge clk);
            k++;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || quotient_o !== 8'd28 || remainder_o !== 8'd4 || div0_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_done: done=%b busy=%b q=%0d r=%0d div0=%b, required 1 0 28 4 0", done, busy, quotient_o, remainder_o, div0_o);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL basic_pulse: done=%b, required 0", done);
        end
    endtask

    task automatic test_edges;
        logic [7:0] a [4] = '{8'd255, 8'd5, 8'd0, 8'd255};
        logic [7:0] b [4] = '{8'd1, 8'd9, 8'd3, 8'd255};
        logic [7:0] eq [4] = '{8'd255, 8'd0, 8'd0, 8'd1};
        logic [7:0] er [4] = '{8'd0, 8'd5, 8'd0, 8'd0};
        int k;
        for (int i = 0; i < 4; i++) begin
            start_op(a[i], b[i]);
            wait_done(k);
            checks++;
            if (k !== 8 || quotient_o !== eq[i] || remainder_o !== er[i] || div0_o !== 1'b0) begin
                failures++;
                $display("FAIL edge %0d/%0d: lat=%0d q=%0d r=%0d div0=%b, required 8 %0d %0d 0", a[i], b[i], k, quotient_o, remainder_o, div0_o, eq[i], er[i]);
            end
            repeat (3) @(negedge clk);
            checks++;
            if (quotient_o !== eq[i] || remainder_o !== er[i] || done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL edge_hold %0d/%0d: q=%0d r=%0d done=%b busy=%b, required %0d %0d 0 0", a[i], b[i], quotient_o, remainder_o, done, busy, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_div0;
        int k;
        start_op(8'd77, 8'd0);
        wait_done(k);
        checks++;
        if (k !== 8 || quotient_o !== 8'd255 || remainder_o !== 8'd77 || div0_o !== 1'b1) begin
            failures++;
            $display("FAIL div0: lat=%0d q=%0d r=%0d div0=%b, required 8 255 77 1", k, quotient_o, remainder_o, div0_o);
        end
        start_op(8'd9, 8'd2);
        wait_done(k);
        checks++;
        if (k !== 8 || quotient_o !== 8'd4 || remainder_o !== 8'd1 || div0_o !== 1'b0) begin
            failures++;
            $display("FAIL div0_clear: lat=%0d q=%0d r=%0d div0=%b, required 8 4 1 0", k, quotient_o, remainder_o, div0_o);
        end
    endtask

    task automatic test_abort;
        int dones = 0;
        int first = -1;
        start_op(8'd100, 8'd3);
        repeat (3) @(negedge clk);
        start_op(8'd250, 8'd16);
        for (int k = 0; k <= 12; k++) begin
            if (done) begin
                dones++;
                if (first < 0) first = k;
                checks++;
                if (quotient_o !== 8'd15 || remainder_o !== 8'd10) begin
                    failures++;
                    $display("FAIL abort_result: q=%0d r=%0d, required 15 10", quotient_o, remainder_o);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (dones !== 1 || first !== 8) begin
            failures++;
            $display("FAIL abort_done: pulses=%0d at=%0d, required 1 at 8", dones, first);
        end
    endtask

    task automatic test_async_reset;
        int k;
        int dones = 0;
        start_op(8'd200, 8'd7);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, div0_o, quotient_o, remainder_o} !== 19'd0) begin
            failures++;
            $display("FAIL async_reset: busy=%b done=%b div0=%b q=%0d r=%0d, required all 0", busy, done, div0_o, quotient_o, remainder_o);
        end
        repeat (12) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL reset_no_done: pulses=%0d, required 0", dones);
        end
        start_op(8'd60, 8'd7);
        wait_done(k);
        checks++;
        if (k !== 8 || quotient_o !== 8'd8 || remainder_o !== 8'd4 || div0_o !== 1'b0) begin
            failures++;
            $display("FAIL after_reset: lat=%0d q=%0d r=%0d div0=%b, required 8 8 4 0", k, quotient_o, remainder_o, div0_o);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] a, b;
        int k;
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        start_op(a, b);
        for (int n = 0; n < 1000; n++) begin
            wait_done(k);
            checks++;
            if (k !== 8 || quotient_o !== ref_q(a, b) || remainder_o !== ref_r(a, b) || div0_o !== (b == 0)) begin
                failures++;
                $display("FAIL random op %0d %0d/%0d: lat=%0d q=%0d r=%0d div0=%b, required 8 %0d %0d %0d",
                         n, a, b, k, quotient_o, remainder_o, div0_o, ref_q(a, b), ref_r(a, b), b == 0);
            end
            if (n == 999) break;
            a = $urandom_range(0, 255);
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            start = 1'b1;
            dividend_i = a;
            divisor_i = b;
            @(negedge clk);
            start = 1'b0;
            dividend_i = $urandom_range(0, 255);
            divisor_i = $urandom_range(0, 255);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_edges();
        test_div0();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
